io_bank: RTL and testbench

IO_BANK -- requirements
Module: io_bank

---
 rtl/io_bank_pkg.sv | 13 +
 rtl/io_bank_sync.sv | 24 ++
 rtl/io_bank.sv | 134 +++++++++++++
 tb/tb_io_bank.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// rtl/io_bank_pkg.sv - shared path-mode constants for the io_bank pad bank
package io_bank_pkg;

    localparam int IO_MODE_PASS  = 0;
    localparam int IO_MODE_REG   = 1;
    localparam int IO_MODE_GEAR2 = 2;

    // True when a path-mode parameter names one of the supported modes
    function automatic bit io_mode_legal(input int mode);
        return (mode >= IO_MODE_PASS) && (mode <= IO_MODE_GEAR2);
    endfunction

endpackage

// File: rtl/io_bank_sync.sv
// rtl/io_bank_sync.sv - per-bit two-flop synchroniser for asynchronous pad inputs
module io_bank_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Free-running two-stage capture; deliberately ignores ce so pads are always resolved
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_bank.sv
// rtl/io_bank.sv - pad IO bank with pass/SDR/2:1 gearbox paths; define IO_BANK_SYNC_EN to synchronise pad_i
module io_bank
    import io_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int OUT_MODE = IO_MODE_REG,
    parameter int IN_MODE  = IO_MODE_REG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             oe,
    input  logic             hold,
    input  logic [WIDTH-1:0] dout0,
    input  logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] din0,
    output logic [WIDTH-1:0] din1,
    output logic             din_valid,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oe,
    output logic             phase
);

    if ((WIDTH < 1) || (WIDTH > 64)) begin : g_bad_width
        $error("io_bank: WIDTH must be within 1..64");
    end
    if (!io_mode_legal(OUT_MODE)) begin : g_bad_out_mode
        $error("io_bank: OUT_MODE must be 0, 1 or 2");
    end
    if (!io_mode_legal(IN_MODE)) begin : g_bad_in_mode
        $error("io_bank: IN_MODE must be 0, 1 or 2");
    end

    // Inputs that some mode combinations leave unread
    logic unused_inputs;
    assign unused_inputs = ^{dout1, hold};

    logic [WIDTH-1:0] pad_s;

`ifdef IO_BANK_SYNC_EN
    io_bank_sync #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_i),
        .q   (pad_s)
    );
`else
    assign pad_s = pad_i;
`endif

    // Gearbox phase shared by both directions; advances only on enabled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
        end else if (ce) begin
            phase <= ~phase;
        end
    end

    if (OUT_MODE == IO_MODE_PASS) begin : g_out_pass
        assign pad_o  = dout0;
        assign pad_oe = {WIDTH{oe}};
    end else if (OUT_MODE == IO_MODE_REG) begin : g_out_reg
        // Single-rate output register with enable travelling alongside the data
        always_ff @(posedge clk) begin
            if (rst) begin
                pad_o  <= '0;
                pad_oe <= '0;
            end else if (ce) begin
                pad_o  <= dout0;
                pad_oe <= {WIDTH{oe}};
            end
        end
    end else begin : g_out_gear
        logic [WIDTH-1:0] stash;
        // Phase 0 launches dout0 and parks dout1; phase 1 launches the parked word
        always_ff @(posedge clk) begin
            if (rst) begin
                pad_o  <= '0;
                pad_oe <= '0;
                stash  <= '0;
            end else if (ce) begin
                pad_oe <= {WIDTH{oe}};
                if (!phase) begin
                    pad_o <= dout0;
                    stash <= dout1;
                end else begin
                    pad_o <= stash;
                end
            end
        end
    end

    if (IN_MODE == IO_MODE_PASS) begin : g_in_pass
        assign din0      = pad_s;
        assign din1      = '0;
        assign din_valid = 1'b1;
    end else if (IN_MODE == IO_MODE_REG) begin : g_in_reg
        assign din1      = '0;
        assign din_valid = ce;
        // Single-rate capture, frozen while hold is asserted
        always_ff @(posedge clk) begin
            if (rst) begin
                din0 <= '0;
            end else if (ce && !hold) begin
                din0 <= pad_s;
            end
        end
    end else begin : g_in_gear
        logic [WIDTH-1:0] stage;
        // Phase 0 stages the first word; phase 1 publishes the pair and pulses din_valid.
        // din_valid is rewritten every cycle so a pulse can never stretch across a ce gap.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage     <= '0;
                din0      <= '0;
                din1      <= '0;
                din_valid <= 1'b0;
            end else begin
                din_valid <= ce && phase && !hold;
                if (ce && !hold) begin
                    if (!phase) begin
                        stage <= pad_s;
                    end else begin
                        din0 <= stage;
                        din1 <= pad_s;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_io_bank.sv
// tb/tb_io_bank.sv - scoreboard bench for io_bank in pass, SDR and gearbox configurations
module tb_io_bank;

`ifdef IO_BANK_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    localparam int S_PHASE   = 0;
    localparam int S_R_PO    = 1;
    localparam int S_R_POE   = 2;
    localparam int S_R_DIN0  = 3;
    localparam int S_FLAGS   = 4;
    localparam int S_G_PO    = 5;
    localparam int S_G_POE   = 6;
    localparam int S_G_DIN0  = 7;
    localparam int S_G_DIN1  = 8;
    localparam int S_G_DV    = 9;
    localparam int S_P_PO    = 10;
    localparam int S_P_POE   = 11;
    localparam int S_P_DIN0  = 12;
    localparam int S_D1_ZERO = 13;

    logic       clk = 1'b0;
    logic       rst, ce, oe, hold;
    logic [3:0] dout0, dout1, pad_i;

    logic [3:0] r_din0, r_din1, r_po, r_poe;
    logic       r_dv, r_ph;
    logic [3:0] g_din0, g_din1, g_po, g_poe;
    logic       g_dv, g_ph;
    logic [3:0] p_din0, p_din1, p_po, p_poe;
    logic       p_dv, p_ph;

    io_bank #(.WIDTH(4), .OUT_MODE(1), .IN_MODE(1)) u_reg (
        .clk(clk), .rst(rst), .ce(ce), .oe(oe), .hold(hold),
        .dout0(dout0), .dout1(dout1), .din0(r_din0), .din1(r_din1), .din_valid(r_dv),
        .pad_i(pad_i), .pad_o(r_po), .pad_oe(r_poe), .phase(r_ph)
    );

    io_bank #(.WIDTH(4), .OUT_MODE(2), .IN_MODE(2)) u_gear (
        .clk(clk), .rst(rst), .ce(ce), .oe(oe), .hold(hold),
        .dout0(dout0), .dout1(dout1), .din0(g_din0), .din1(g_din1), .din_valid(g_dv),
        .pad_i(pad_i), .pad_o(g_po), .pad_oe(g_poe), .phase(g_ph)
    );

    io_bank #(.WIDTH(4), .OUT_MODE(0), .IN_MODE(0)) u_pass (
        .clk(clk), .rst(rst), .ce(ce), .oe(oe), .hold(hold),
        .dout0(dout0), .dout1(dout1), .din0(p_din0), .din1(p_din1), .din_valid(p_dv),
        .pad_i(pad_i), .pad_o(p_po), .pad_oe(p_poe), .phase(p_ph)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         sig;
        logic [3:0] exp;
    } sb_t;

    sb_t        sb[$];
    int         cyc     = 0;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] pad_hist [0:4095];

    logic       ph;
    logic [3:0] m_rpo, m_rpoe, m_rdin0;
    logic [3:0] m_gpo, m_gpoe, m_stash, m_stage, m_gdin0, m_gdin1;
    logic       m_gdv;

    function automatic logic [3:0] pad_at(input int i);
        if (i < 0) return 4'h0;
        return pad_hist[i];
    endfunction

    function automatic logic [3:0] observe(input int s);
        case (s)
            S_PHASE:   return {1'b0, p_ph, r_ph, g_ph};
            S_R_PO:    return r_po;
            S_R_POE:   return r_poe;
            S_R_DIN0:  return r_din0;
            S_FLAGS:   return {2'b00, r_dv, p_dv};
            S_G_PO:    return g_po;
            S_G_POE:   return g_poe;
            S_G_DIN0:  return g_din0;
            S_G_DIN1:  return g_din1;
            S_G_DV:    return {3'b000, g_dv};
            S_P_PO:    return p_po;
            S_P_POE:   return p_poe;
            S_P_DIN0:  return p_din0;
            default:   return r_din1 | p_din1;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_PHASE:   return "phase";
            S_R_PO:    return "sdr_pad_o";
            S_R_POE:   return "sdr_pad_oe";
            S_R_DIN0:  return "sdr_din0";
            S_FLAGS:   return "din_valid_sdr_pass";
            S_G_PO:    return "gear_pad_o";
            S_G_POE:   return "gear_pad_oe";
            S_G_DIN0:  return "gear_din0";
            S_G_DIN1:  return "gear_din1";
            S_G_DV:    return "gear_din_valid";
            S_P_PO:    return "pass_pad_o";
            S_P_POE:   return "pass_pad_oe";
            S_P_DIN0:  return "pass_din0";
            default:   return "din1_zero";
        endcase
    endfunction

    task automatic expect_at(input int due, input int s, input logic [3:0] v);
        sb_t e;
        e.due = due;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    // Apply one cycle of stimulus, advance the reference model, queue its expectations for the next edge
    task automatic drive(input logic c, input logic o, input logic h,
                         input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] p);
        logic [3:0] ps;
        rst = 1'b0; ce = c; oe = o; hold = h;
        dout0 = d0; dout1 = d1; pad_i = p;
        pad_hist[cyc] = p;
        ps = pad_at(cyc - SL);
        m_gdv = c & ph & ~h;
        if (c) begin
            m_rpo  = d0;
            m_rpoe = {4{o}};
            m_gpoe = {4{o}};
            if (!h) m_rdin0 = ps;
            if (!ph) begin
                m_gpo   = d0;
                m_stash = d1;
                if (!h) m_stage = ps;
            end else begin
                m_gpo = m_stash;
                if (!h) begin
                    m_gdin0 = m_stage;
                    m_gdin1 = ps;
                end
            end
            ph = ~ph;
        end
        expect_at(cyc + 1, S_PHASE,   {1'b0, ph, ph, ph});
        expect_at(cyc + 1, S_R_PO,    m_rpo);
        expect_at(cyc + 1, S_R_POE,   m_rpoe);
        expect_at(cyc + 1, S_R_DIN0,  m_rdin0);
        expect_at(cyc + 1, S_FLAGS,   {2'b00, c, 1'b1});
        expect_at(cyc + 1, S_G_PO,    m_gpo);
        expect_at(cyc + 1, S_G_POE,   m_gpoe);
        expect_at(cyc + 1, S_G_DIN0,  m_gdin0);
        expect_at(cyc + 1, S_G_DIN1,  m_gdin1);
        expect_at(cyc + 1, S_G_DV,    {3'b000, m_gdv});
        expect_at(cyc + 1, S_P_PO,    d0);
        expect_at(cyc + 1, S_P_POE,   {4{o}});
        expect_at(cyc + 1, S_P_DIN0,  (SL == 0) ? p : pad_at(cyc + 1 - SL));
        expect_at(cyc + 1, S_D1_ZERO, 4'h0);
    endtask

    task automatic test_reset(input logic c, input logic h);
        logic [3:0] got;
        for (int n = 0; n < 3; n++) begin
            rst = 1'b1; ce = c; hold = h; oe = 1'b1;
            dout0 = 4'hF; dout1 = 4'hF; pad_i = 4'h0;
            pad_hist[cyc] = 4'h0;
            expect_at(cyc + 1, S_PHASE,   4'h0);
            expect_at(cyc + 1, S_R_PO,    4'h0);
            expect_at(cyc + 1, S_R_POE,   4'h0);
            expect_at(cyc + 1, S_R_DIN0,  4'h0);
            expect_at(cyc + 1, S_FLAGS,   {2'b00, c, 1'b1});
            expect_at(cyc + 1, S_G_PO,    4'h0);
            expect_at(cyc + 1, S_G_POE,   4'h0);
            expect_at(cyc + 1, S_G_DIN0,  4'h0);
            expect_at(cyc + 1, S_G_DIN1,  4'h0);
            expect_at(cyc + 1, S_G_DV,    4'h0);
            expect_at(cyc + 1, S_P_PO,    4'hF);
            expect_at(cyc + 1, S_P_POE,   4'hF);
            expect_at(cyc + 1, S_P_DIN0,  4'h0);
            expect_at(cyc + 1, S_D1_ZERO, 4'h0);
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
        rst = 1'b0;
        ph = 1'b0;
        m_rpo = 4'h0; m_rpoe = 4'h0; m_rdin0 = 4'h0;
        m_gpo = 4'h0; m_gpoe = 4'h0; m_stash = 4'h0; m_stage = 4'h0;
        m_gdin0 = 4'h0; m_gdin1 = 4'h0; m_gdv = 1'b0;
    endtask

    task automatic test_out_reg();
        logic [3:0] got;
        logic [3:0] dv [6] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'hF, 4'hA};
        logic       ov [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int n = 0; n < 6; n++) begin
            expect_at(cyc + 1, S_R_PO,  dv[n]);
            expect_at(cyc + 1, S_R_POE, ov[n] ? 4'hF : 4'h0);
            drive(1'b1, ov[n], 1'b0, dv[n], ~dv[n], 4'(n));
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_out_gear();
        logic [3:0] got;
        logic [3:0] d0 [6] = '{4'h3, 4'hF, 4'h6, 4'h0, 4'h5, 4'h7};
        logic [3:0] d1 [6] = '{4'hC, 4'hF, 4'h9, 4'h0, 4'hA, 4'h7};
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) begin
                expect_at(cyc + 1, S_G_PO, d0[n]);
                expect_at(cyc + 2, S_G_PO, d1[n]);
            end
            expect_at(cyc + 1, S_PHASE, (n % 2 == 0) ? 4'h7 : 4'h0);
            drive(1'b1, 1'b1, 1'b0, d0[n], d1[n], 4'hE);
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_in_reg_hold();
        logic [3:0] got;
        logic [3:0] p;
        logic       h;
        for (int n = 0; n < 12; n++) begin
            p = (n < 3) ? 4'h1 : (n < 9) ? 4'(n - 1) : 4'h8;
            h = (n >= 3) && (n < 9);
            if (h) expect_at(cyc + 1, S_R_DIN0, 4'h1);
            if (n == 9) expect_at(cyc + 1 + SL, S_R_DIN0, 4'h8);
            drive(1'b1, 1'b1, h, 4'(n), 4'(15 - n), p);
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_in_gear();
        logic [3:0] got;
        logic [3:0] pv [12] = '{4'h5, 4'h9, 4'hA, 4'h6, 4'h3, 4'hC, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int n = 0; n < 12; n++) begin
            if (n < 8) begin
                if (n % 2 == 1) begin
                    expect_at(cyc + 1 + SL, S_G_DIN0, pv[n - 1]);
                    expect_at(cyc + 1 + SL, S_G_DIN1, pv[n]);
                    expect_at(cyc + 1 + SL, S_G_DV,   4'h1);
                end else begin
                    expect_at(cyc + 1 + SL, S_G_DV,   4'h0);
                end
            end
            drive(1'b1, 1'b0, 1'b0, 4'h2, 4'h4, pv[n]);
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_ce_pause();
        logic [3:0] got;
        logic       cv [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] d0 [8] = '{4'h3, 4'hF, 4'hE, 4'hD, 4'h5, 4'h6, 4'hB, 4'h0};
        logic [3:0] d1 [8] = '{4'hC, 4'hF, 4'hE, 4'hD, 4'h5, 4'h9, 4'hB, 4'h0};
        logic [3:0] po [8] = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hC, 4'h6, 4'h9, 4'h9};
        logic [3:0] pp [8] = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h7, 4'h0, 4'h0};
        for (int n = 0; n < 8; n++) begin
            expect_at(cyc + 1, S_G_PO,  po[n]);
            expect_at(cyc + 1, S_PHASE, pp[n]);
            if (!cv[n]) expect_at(cyc + 1, S_G_DV, 4'h0);
            drive(cv[n], 1'b1, 1'b0, d0[n], d1[n], 4'(n + 3));
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_sync_latency();
        logic [3:0] got;
        for (int n = 0; n < 8; n++) begin
            if (n == 3) begin
                expect_at(cyc + 1 + SL, S_R_DIN0, 4'hB);
                expect_at(cyc + ((SL == 0) ? 1 : SL), S_P_DIN0, 4'hB);
            end
            drive(1'b1, 1'b1, 1'b0, 4'h1, 4'h2, (n < 3) ? 4'h0 : 4'hB);
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        for (int n = 0; n < 40; n++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                  4'($urandom), 4'($urandom), 4'($urandom));
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        int         lead;
        lead = ph ? 2 : 1;
        for (int n = 0; n < lead + 2; n++) begin
            if (n == lead) begin
                test_reset(1'b1, 1'b0);
                expect_at(cyc + 1, S_G_PO, 4'h3);
                expect_at(cyc + 2, S_G_PO, 4'hC);
            end
            if (n < lead) drive(1'b1, 1'b1, 1'b0, 4'h9, 4'h6, 4'hD);
            else          drive(1'b1, 1'b1, 1'b0, (n == lead) ? 4'h3 : 4'hF, (n == lead) ? 4'hC : 4'hF, 4'h0);
            @(posedge clk); #1; cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    got = observe(sb[i].sig);
                    n_total++;
                    if (got !== sb[i].exp)
                        $display("FAIL %s cycle %0d: got %h expected %h", sig_name(sb[i].sig), cyc, got, sb[i].exp);
                    else
                        n_pass++;
                    sb.delete(i);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; oe = 1'b0; hold = 1'b0;
        dout0 = 4'h0; dout1 = 4'h0; pad_i = 4'h0;
        ph = 1'b0;
        test_reset(1'b0, 1'b1);
        test_out_reg();
        test_out_gear();
        test_in_reg_hold();
        test_in_gear();
        test_ce_pause();
        test_sync_latency();
        test_back_to_back();
        test_reset_mid();
        n_total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
